// File: rtl/mac_seq_ctrl_if.sv
// mac_seq_ctrl_if: request, sample-write, MAC and result-handshake signals
// that connect the MAC sequencer to its filter datapath and consumer.
// slave  = the sequencer side, master = the datapath/consumer side.
interface mac_seq_ctrl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int WIDTH      = 24,
  parameter int OUT_WIDTH  = 16
);
  logic                  start;
  logic                  ready;
  logic                  samp_wr;
  logic [ADDR_WIDTH-1:0] coef_addr;
  logic [ADDR_WIDTH-1:0] samp_addr;
  logic                  mac_clr;
  logic                  mac_wr_en;
  logic [WIDTH-1:0]      mac_acc;
  logic [OUT_WIDTH-1:0]  result;
  logic                  valid;
  logic                  ack;

  modport slave (
    input  start, samp_wr, mac_acc, ack,
    output ready, coef_addr, samp_addr, mac_clr, mac_wr_en, result, valid
  );

  modport master (
    output start, samp_wr, mac_acc, ack,
    input  ready, coef_addr, samp_addr, mac_clr, mac_wr_en, result, valid
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: runs one NTAPS-long dot product per request on an external
// MAC, walking the coefficient ROM forwards and the sample ring backwards
// from the newest sample, then returns the formatted accumulator on a
// valid/ack handshake.
// Optional feature macro: MAC_SEQ_CTRL_SAT_EN (saturate the result to the
// signed OUT_WIDTH range instead of truncating to the low bits).
//
// state | meaning
// IDLE  | ready for a run request
// CLEAR | MAC loads 0, tap 0 addresses presented
// ACCUM | NTAPS cycles of accumulation, next tap addressed each cycle
// CAPT  | accumulator registered into the result
// OUT   | result valid, waiting for ack
module mac_seq_ctrl #(
  parameter int NTAPS      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int WIDTH      = 24,
  parameter int OUT_WIDTH  = 16
) (
  input logic         clk,
  input logic         rst,
  mac_seq_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_ACCUM = 3'd2;
  localparam logic [2:0] S_CAPT  = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  localparam int CW = $clog2(NTAPS);
  localparam logic [ADDR_WIDTH-1:0] LAST_SLOT = ADDR_WIDTH'(NTAPS - 1);
  localparam logic [CW-1:0]         REM_INIT  = CW'(NTAPS - 1);

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] base_next;
  logic [ADDR_WIDTH-1:0] tap;
  logic [ADDR_WIDTH-1:0] samp;
  logic [ADDR_WIDTH-1:0] samp_dec;
  logic [CW-1:0]         rem;
  logic [OUT_WIDTH-1:0]  result;
  logic [OUT_WIDTH-1:0]  fmt_val;
  logic                  addr_on;

  // Ring pointer advance with explicit wrap so NTAPS need not be a power of two
  always_comb begin
    base_next = base;
    if (bus.samp_wr) begin
      base_next = (base == LAST_SLOT) ? '0 : base + ADDR_WIDTH'(1);
    end
  end

  // Walking backwards through the ring, newest sample first
  always_comb begin
    samp_dec = (samp == '0) ? LAST_SLOT : samp - ADDR_WIDTH'(1);
  end

  // Base pointer tracks the newest written slot in every state
  always_ff @(posedge clk) begin
    if (rst) begin
      base <= '0;
    end else begin
      base <= base_next;
    end
  end

  // Run sequencing; samp holds the run's own copy of the base, so sample
  // writes during a run do not disturb its addressing. rem counts the
  // remaining ACCUM cycles down to the terminal count of zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      tap   <= '0;
      samp  <= '0;
      rem   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state <= S_CLEAR;
            tap   <= '0;
            samp  <= base_next;
          end
        end
        S_CLEAR: begin
          state <= S_ACCUM;
          tap   <= tap + ADDR_WIDTH'(1);
          samp  <= samp_dec;
          rem   <= REM_INIT;
        end
        S_ACCUM: begin
          if (rem == '0) begin
            state <= S_CAPT;
          end else begin
            rem  <= rem - CW'(1);
            tap  <= tap + ADDR_WIDTH'(1);
            samp <= samp_dec;
          end
        end
        S_CAPT: begin
          state <= S_OUT;
        end
        S_OUT: begin
          if (bus.ack) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef MAC_SEQ_CTRL_SAT_EN
  localparam logic signed [WIDTH-1:0] SAT_MAX =
    {{(WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  // Clamp the signed accumulator into the signed result range
  always_comb begin
    fmt_val = bus.mac_acc[OUT_WIDTH-1:0];
    if ($signed(bus.mac_acc) > SAT_MAX) begin
      fmt_val = SAT_MAX[OUT_WIDTH-1:0];
    end else if ($signed(bus.mac_acc) < SAT_MIN) begin
      fmt_val = SAT_MIN[OUT_WIDTH-1:0];
    end
  end
`else
  // Keep the low bits; overflow wraps silently
  always_comb begin
    fmt_val = bus.mac_acc[OUT_WIDTH-1:0];
  end
`endif

  // Result register, loaded once per run and held through the handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
    end else if (state == S_CAPT) begin
      result <= fmt_val;
    end
  end

  // The last ACCUM cycle has no further tap to address, so it reads 0 like idle
  assign addr_on = (state == S_CLEAR) || ((state == S_ACCUM) && (rem != '0));

  assign bus.ready     = (state == S_IDLE);
  assign bus.valid     = (state == S_OUT);
  assign bus.mac_clr   = (state == S_CLEAR);
  assign bus.mac_wr_en = (state == S_CLEAR) || (state == S_ACCUM);
  assign bus.coef_addr = addr_on ? tap  : '0;
  assign bus.samp_addr = addr_on ? samp : '0;
  assign bus.result    = result;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: drives mac_seq_ctrl with a coefficient ROM, a sample ring
// RAM and a MAC built around it; expected results are the dot product over
// the ring taken straight from array contents and a ring index kept in an int.
module tb_mac_seq_ctrl;
  localparam int N  = 4;
  localparam int AW = 3;
  localparam int W  = 24;
  localparam int OW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_seq_ctrl_if #(.ADDR_WIDTH(AW), .WIDTH(W), .OUT_WIDTH(OW)) bus ();

  mac_seq_ctrl #(.NTAPS(N), .ADDR_WIDTH(AW), .WIDTH(W), .OUT_WIDTH(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Datapath around the sequencer: one-cycle ROM/RAM reads feeding a MAC
  int rom [N];
  int ram [N];
  int coef_q;
  int samp_q;
  logic [W-1:0] acc;
  logic         ovr_en;
  logic [W-1:0] ovr_val;

  always @(posedge clk) begin
    coef_q <= (bus.coef_addr < AW'(N)) ? rom[bus.coef_addr[1:0]] : 0;
    samp_q <= (bus.samp_addr < AW'(N)) ? ram[bus.samp_addr[1:0]] : 0;
    if (bus.mac_wr_en) acc <= bus.mac_clr ? '0 : acc + W'(coef_q * samp_q);
  end
  assign bus.mac_acc = ovr_en ? ovr_val : acc;

  int errors = 0;
  int checks = 0;
  int model_base = 0;

  task automatic chk(input string tag, input longint obs, input longint exp_v);
    checks++;
    if (obs != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OW-1:0] fmt_ref(input longint s);
    longint v;
    v = s & 64'hFFFFFF;
    if (v >= 64'sd8388608) v = v - 64'sd16777216;
`ifdef MAC_SEQ_CTRL_SAT_EN
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
`endif
    return OW'(v);
  endfunction

  function automatic longint dot(input int rb);
    longint s;
    s = 0;
    for (int i = 0; i < N; i++) s += longint'(rom[i]) * longint'(ram[(rb - i + N) % N]);
    return s;
  endfunction

  task automatic pulse_wr(input bit write_data);
    model_base = (model_base + 1) % N;
    if (write_data) ram[model_base] = int'($urandom_range(0, 4095)) - 2048;
    bus.samp_wr = 1'b1;
    tick();
    bus.samp_wr = 1'b0;
  endtask

  task automatic do_run(input bit wr_acc, input int ack_dly, input bit rnd_wr,
                        output logic [OW-1:0] got);
    int rb;
    logic [OW-1:0] exp_r;
    chk("ready_before_accept", bus.ready, 1);
    if (wr_acc) model_base = (model_base + 1) % N;
    rb = model_base;
    exp_r = ovr_en ? fmt_ref(longint'(ovr_val)) : fmt_ref(dot(rb));
    bus.start = 1'b1;
    bus.samp_wr = wr_acc;
    tick();
    bus.start = 1'b0;
    bus.samp_wr = 1'b0;
    chk("clear_clr", bus.mac_clr, 1);
    chk("clear_wren", bus.mac_wr_en, 1);
    chk("clear_ready", bus.ready, 0);
    chk("coef_addr_tap0", bus.coef_addr, 0);
    chk("samp_addr_tap0", bus.samp_addr, rb);
    for (int k = 0; k < N; k++) begin
      if (rnd_wr && ($urandom_range(0, 3) == 0)) begin
        bus.samp_wr = 1'b1;
        model_base = (model_base + 1) % N;
      end
      tick();
      bus.samp_wr = 1'b0;
      chk("accum_clr", bus.mac_clr, 0);
      chk("accum_wren", bus.mac_wr_en, 1);
      if (k < N - 1) begin
        chk("coef_addr", bus.coef_addr, k + 1);
        chk("samp_addr", bus.samp_addr, (rb - k - 1 + N) % N);
      end
    end
    tick();
    chk("capt_wren", bus.mac_wr_en, 0);
    chk("capt_clr", bus.mac_clr, 0);
    chk("capt_valid", bus.valid, 0);
    chk("capt_coef_addr", bus.coef_addr, 0);
    chk("capt_samp_addr", bus.samp_addr, 0);
    tick();
    chk("out_valid", bus.valid, 1);
    chk("out_ready", bus.ready, 0);
    chk("out_data", bus.result, exp_r);
    for (int d = 0; d < ack_dly; d++) begin
      bus.start = 1'b1;
      bus.ack = 1'b0;
      tick();
      chk("hold_valid", bus.valid, 1);
      chk("hold_data", bus.result, exp_r);
      chk("hold_ready", bus.ready, 0);
      chk("hold_wren", bus.mac_wr_en, 0);
    end
    bus.start = 1'b0;
    bus.ack = 1'b1;
    got = bus.result;
    tick();
    bus.ack = 1'b0;
    chk("ack_valid", bus.valid, 0);
    chk("ack_ready", bus.ready, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_base = 0;
  endtask

  logic [OW-1:0] got;

  initial begin
    bus.start = 1'b0;
    bus.samp_wr = 1'b0;
    bus.ack = 1'b0;
    ovr_en = 1'b0;
    ovr_val = '0;
    for (int i = 0; i < N; i++) begin
      rom[i] = 0;
      ram[i] = 0;
    end

    // Reset and idle behaviour
    rst = 1'b1;
    tick();
    tick();
    chk("rst_ready", bus.ready, 1);
    chk("rst_valid", bus.valid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_clr", bus.mac_clr, 0);
    chk("rst_wren", bus.mac_wr_en, 0);
    chk("rst_coef_addr", bus.coef_addr, 0);
    chk("rst_samp_addr", bus.samp_addr, 0);
    rst = 1'b0;
    model_base = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_ready", bus.ready, 1);
      chk("idle_wren", bus.mac_wr_en, 0);
      chk("idle_valid", bus.valid, 0);
    end
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("stray_ack_ready", bus.ready, 1);
    chk("stray_ack_valid", bus.valid, 0);

    // Single run: coefs 1..4, slots 3..0 = 10,20,30,40, base 3
    rom[0] = 1; rom[1] = 2; rom[2] = 3; rom[3] = 4;
    ram[3] = 10; ram[2] = 20; ram[1] = 30; ram[0] = 40;
    for (int i = 0; i < 3; i++) pulse_wr(1'b0);
    do_run(1'b0, 0, 1'b0, got);
    chk("single_result_300", got, 300);

    // Ring wrap from base 1
    pulse_wr(1'b0);
    pulse_wr(1'b0);
    do_run(1'b0, 0, 1'b0, got);

    // Five writes from reset land on slot 1, then accept with a same-cycle write
    do_reset();
    for (int i = 0; i < 5; i++) pulse_wr(1'b0);
    do_run(1'b0, 0, 1'b0, got);
    pulse_wr(1'b0);
    do_run(1'b1, 0, 1'b0, got);

    // Backpressure with start held high
    do_run(1'b0, 10, 1'b0, got);

    // Reset during ACCUM
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("midrun_wren", bus.mac_wr_en, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_base = 0;
    chk("midrun_rst_ready", bus.ready, 1);
    chk("midrun_rst_wren", bus.mac_wr_en, 0);
    chk("midrun_rst_valid", bus.valid, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("no_valid_after_rst", bus.valid, 0);
    end
    do_run(1'b0, 1, 1'b0, got);

    // Overflow formatting
    ovr_en = 1'b1;
    ovr_val = 24'h012345;
    do_run(1'b0, 0, 1'b0, got);
`ifdef MAC_SEQ_CTRL_SAT_EN
    chk("overflow_pos", got, 16'h7FFF);
`else
    chk("overflow_pos", got, 16'h2345);
`endif
    ovr_val = 24'hF00000;
    do_run(1'b0, 0, 1'b0, got);
`ifdef MAC_SEQ_CTRL_SAT_EN
    chk("overflow_neg", got, 16'h8000);
`else
    chk("overflow_neg", got, 16'h0000);
`endif
    ovr_en = 1'b0;

    // Randomized runs
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < N; i++) rom[i] = int'($urandom_range(0, 4095)) - 2048;
      for (int p = int'($urandom_range(0, 5)); p > 0; p--) pulse_wr(1'b1);
      do_run(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b1, got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
